// File: rtl/song_reader.sv
// Song sequencer: walks a song ROM ({song, idx} addressed, synchronous read)
// and hands note/duration pairs to the note player one at a time.
module song_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic [1:0]  song,
    input  logic        note_done,
    output logic [6:0]  rom_addr,
    input  logic [11:0] rom_dout,
    output logic [5:0]  note_to_load,
    output logic [5:0]  duration_to_load,
    output logic        load_new_note,
    output logic        song_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_LOAD    = 3'd3,
        S_WAIT    = 3'd4,
        S_ADVANCE = 3'd5,
        S_END     = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  song_q, song_d;
    logic [6:0]  rom_addr_q, rom_addr_d;
    logic [5:0]  note_q, note_d;
    logic [5:0]  dur_q, dur_d;
    logic        load_q, load_d;
    logic        done_q, done_d;

    // Next-state and next-output computation; a song change beats a pause, which beats sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        song_d  = song_q;
        note_d  = note_q;
        dur_d   = dur_q;
        if (song != song_q) begin
            song_d  = song;
            idx_d   = 5'd0;
            state_d = S_IDLE;
        end else if (!play) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_FETCH;
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    if (rom_dout[5:0] == 6'd0) begin
                        idx_d   = 5'd0;
                        state_d = S_END;
                    end else begin
                        note_d  = rom_dout[11:6];
                        dur_d   = rom_dout[5:0];
                        state_d = S_LOAD;
                    end
                end
                S_LOAD:   state_d = S_WAIT;
                S_WAIT: begin
                    if (note_done) begin
                        state_d = S_ADVANCE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_ADVANCE: begin
                    if (idx_q == 5'd31) begin
                        idx_d   = 5'd0;
                        state_d = S_END;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_FETCH;
                    end
                end
                S_END:    state_d = S_END;
                default:  state_d = S_IDLE;
            endcase
        end
        rom_addr_d = {song_d, idx_d};
        load_d     = (state_d == S_LOAD);
        done_d     = (state_d == S_END);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 5'd0;
            song_q     <= 2'd0;
            rom_addr_q <= 7'd0;
            note_q     <= 6'd0;
            dur_q      <= 6'd0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            song_q     <= song_d;
            rom_addr_q <= rom_addr_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            load_q     <= load_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign load_new_note    = load_q;
    assign song_done        = done_q;

endmodule
